ram_req_adapter: RTL and testbench

- Requester-side front end for the team's dual-port RAM, driving the RAM's read/write port (address, read enable, write enable, write data; one-cycle registered read data).
- Presents a valid/ready request channel and a valid/ready response channel to a core-side client, for example a cache refill or LSU path.
- After reset, zero-fills the whole RAM before accepting client traffic.
- Never asserts read and write enables in the same cycle; the RAM gives read priority, so a simultaneous write would be silently dropped.

---
 rtl/ram_req_adapter_if.sv | 33 +++
 rtl/ram_req_adapter.sv | 105 ++++++++++
 tb/tb_ram_req_adapter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_req_adapter_if.sv
// Client request/response channel plus the RAM read/write port of the adapter.
// The slave modport is the adapter; master is whatever drives the client side and models the RAM.
interface ram_req_adapter_if #(
    parameter int DBITS = 8,
    parameter int ABITS = 12
);
    logic             req_valid;
    logic             req_ready;
    logic [ABITS-1:0] req_addr;
    logic             req_we;
    logic [DBITS-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [DBITS-1:0] resp_rdata;
    logic             init_done;
    logic [ABITS-1:0] ram_addr;
    logic             ram_re;
    logic             ram_we;
    logic [DBITS-1:0] ram_wr;
    logic [DBITS-1:0] ram_rd;

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, resp_ready, ram_rd,
        output req_ready, resp_valid, resp_rdata, init_done,
               ram_addr, ram_re, ram_we, ram_wr
    );

    modport master (
        output req_valid, req_addr, req_we, req_wdata, resp_ready, ram_rd,
        input  req_ready, resp_valid, resp_rdata, init_done,
               ram_addr, ram_re, ram_we, ram_wr
    );
endinterface

// File: rtl/ram_req_adapter.sv
// Requester front end for the dual-port RAM: zero-fills the RAM after reset, then turns
// valid/ready requests into RAM accesses and returns read data through a 2-entry FIFO.
module ram_req_adapter #(
    parameter int DBITS = 8,
    parameter int ABITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    ram_req_adapter_if.slave  bus
);
    localparam int               DEPTH = 1 << ABITS;
    localparam logic [ABITS-1:0] LAST  = ABITS'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] init_cnt_q, init_cnt_d;
    logic             init_done_q, init_done_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, wr_ptr_q;
    logic             push, pop, credit, req_ready, fire;
    logic [DBITS-1:0] head;

    // Next-state logic: INIT walks every address once, then RUN is held until reset.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (state_q == S_INIT) begin
            init_cnt_d = init_cnt_q + ABITS'(1);
            if (init_cnt_q == LAST) begin
                state_d     = S_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    // A slot is owed to every queued or in-flight read; a same-cycle pop frees one early.
    assign pop        = (count_q != 2'd0) && bus.resp_ready;
    assign push       = inflight_q;
    assign credit     = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
    assign req_ready  = (state_q == S_RUN) && (credit || pop);
    assign fire       = bus.req_valid && req_ready;
    assign inflight_d = fire && !bus.req_we;
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        bus.ram_addr = '0;
        bus.ram_wr   = '0;
        bus.ram_re   = 1'b0;
        bus.ram_we   = 1'b0;
        if (rst) begin
            if (state_q == S_INIT) begin
                bus.ram_addr = init_cnt_q;
                bus.ram_we   = 1'b1;
            end else begin
                bus.ram_addr = bus.req_addr;
                bus.ram_wr   = bus.req_wdata;
                bus.ram_we   = fire && bus.req_we;
                bus.ram_re   = fire && !bus.req_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            assert (!(push && !pop && count_q == 2'd2));
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [DBITS-1:0] slot_q;
            always_ff @(posedge clk) begin
                if (!rst)
                    slot_q <= '0;
                else if (push && (wr_ptr_q == 1'(gi)))
                    slot_q <= bus.ram_rd;
            end
        end
    endgenerate

    assign head           = rd_ptr_q ? g_slot[1].slot_q : g_slot[0].slot_q;
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (count_q != 2'd0);
    assign bus.resp_rdata = head;
    assign bus.init_done  = init_done_q;
endmodule

// File: tb/tb_ram_req_adapter.sv
// Directed and random checks of ram_req_adapter against a behavioural read-priority RAM
// and a client-side reference memory.
module tb_ram_req_adapter;
    localparam int DB = 8;
    localparam int AB = 4;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_req_adapter_if #(.DBITS(DB), .ABITS(AB)) bus ();
    ram_req_adapter #(.DBITS(DB), .ABITS(AB)) dut (.clk(clk), .rst(rst), .bus(bus));

    // RAM with registered read data; read wins over write, as in the real part.
    logic [DB-1:0] ram_mem [DEPTH];
    logic [DB-1:0] ram_rd_q = '0;
    always @(posedge clk) begin
        if (bus.ram_re)      ram_rd_q <= ram_mem[bus.ram_addr];
        else if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wr;
    end
    assign bus.ram_rd = ram_rd_q;

    logic both_seen = 1'b0;
    always @(negedge clk) if (bus.ram_re && bus.ram_we) both_seen = 1'b1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          v, we;
        logic [AB-1:0] a;
        logic [DB-1:0] wd;
        logic          rr;
        logic          e_rdy, e_re, e_we, e_rv;
        logic [DB-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(logic v, logic we, logic [AB-1:0] a, logic [DB-1:0] wd, logic rr,
                                logic erdy, logic ere, logic ewe, logic erv, logic [DB-1:0] erd);
        vec_t t;
        t.v = v; t.we = we; t.a = a; t.wd = wd; t.rr = rr;
        t.e_rdy = erdy; t.e_re = ere; t.e_we = ewe; t.e_rv = erv; t.e_rd = erd;
        return t;
    endfunction

    // Called in the first cycle with rst released: expects DEPTH zero-fill cycles.
    task automatic check_init(input string tag);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd9;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk($sformatf("%s_init%0d", tag, i),
                64'({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wr, bus.req_ready,
                     bus.init_done, bus.resp_valid}),
                64'({1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0, 1'b0}));
            next();
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, 64'({bus.init_done, bus.req_ready}), 64'b11);
        next();
    endtask

    task automatic do_read(input logic [AB-1:0] a, input logic [DB-1:0] e, input string name);
        bit fired = 0;
        bit got   = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.resp_ready = 1'b1;
        for (int k = 0; k < 20 && !fired; k++) begin
            @(negedge clk);
            fired = bus.req_ready;
            next();
        end
        bus.req_valid = 1'b0;
        chk({name, "_fire"}, 64'(fired), 64'(1));
        for (int k = 0; k < 20 && fired && !got; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1;
                chk({name, "_lat"}, 64'(k + 1), 64'(2));
                chk({name, "_data"}, 64'(bus.resp_rdata), 64'(e));
            end
            next();
        end
        chk({name, "_resp"}, 64'(got), 64'(1));
    endtask

    vec_t          tbl[$];
    logic [DB-1:0] ref_mem [DEPTH];
    logic [DB-1:0] exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.resp_ready = 1'b0;

        // Vector table, applied one entry per cycle after the first init.
        tbl.push_back(mk(1, 1, 4'd3, 8'hA5, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 0, 4'd3, 8'h00, 1, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 0, 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 4'(i), 8'(8'h10 + i), 1, 1, 0, 1, 0, 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 4'(i), 8'h00, 1, 1, 1, 0, (i >= 2), (i >= 2) ? 8'(8'h0E + i) : 8'h00));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 1, 8'h16));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 1, 8'h17));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 4'd4, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 4'd5, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 4'd6, 8'h00, 0, 0, 0, 0, 1, 8'h14));
        tbl.push_back(mk(1, 0, 4'd6, 8'h00, 0, 0, 0, 0, 1, 8'h14));
        tbl.push_back(mk(1, 0, 4'd6, 8'h00, 1, 1, 1, 0, 1, 8'h14));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 1, 8'h15));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 1, 8'h16));
        tbl.push_back(mk(0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 0, 8'h00));

        // Power-up reset and first zero-fill.
        next();
        @(negedge clk);
        chk("rst_ram_off", 64'({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wr}), 64'(0));
        chk("rst_state", 64'({bus.init_done, bus.resp_valid, bus.resp_rdata, bus.req_ready}), 64'(0));
        next(); next();
        rst = 1'b1;
        check_init("pwr");
        do_read(4'd7, 8'h00, "rd7");

        for (int i = 0; i < tbl.size(); i++) begin
            logic [63:0] g, x;
            bus.req_valid = tbl[i].v; bus.req_we = tbl[i].we; bus.req_addr = tbl[i].a;
            bus.req_wdata = tbl[i].wd; bus.resp_ready = tbl[i].rr;
            @(negedge clk);
            g = {40'b0, bus.req_ready, bus.ram_re, bus.ram_we, bus.resp_valid,
                 (tbl[i].e_rv ? bus.resp_rdata : 8'h00),
                 ((tbl[i].e_re || tbl[i].e_we) ? bus.ram_addr : 4'h0),
                 (tbl[i].e_we ? bus.ram_wr : 8'h00)};
            x = {40'b0, tbl[i].e_rdy, tbl[i].e_re, tbl[i].e_we, tbl[i].e_rv, tbl[i].e_rd,
                 ((tbl[i].e_re || tbl[i].e_we) ? tbl[i].a : 4'h0),
                 (tbl[i].e_we ? tbl[i].wd : 8'h00)};
            chk($sformatf("vec%0d", i), g, x);
            next();
        end
        bus.req_valid = 1'b0;

        // Reset one cycle after a read fire: the read is lost and the RAM is wiped.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd3; bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("mid_fire", 64'(bus.req_ready), 64'(1));
        next();
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_force", 64'({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wr, bus.resp_valid}), 64'(0));
        next();
        @(negedge clk);
        chk("mid_hold", 64'({bus.resp_valid, bus.init_done, bus.req_ready}), 64'(0));
        next();
        rst = 1'b1;
        check_init("re");
        do_read(4'd3, 8'h00, "re_rd3");
        do_read(4'd0, 8'h00, "re_rd0");

        // Random traffic against a client-side reference memory.
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        begin
            bit pend = 0;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                if (!pend) begin
                    if ($urandom_range(0, 9) < 7) begin
                        bus.req_valid = 1'b1;
                        bus.req_we    = 1'($urandom_range(0, 1));
                        bus.req_addr  = 4'($urandom_range(0, DEPTH - 1));
                        bus.req_wdata = 8'($urandom_range(0, 255));
                        pend = 1;
                    end else begin
                        bus.req_valid = 1'b0;
                    end
                end
                bus.resp_ready = ($urandom_range(0, 9) < 6);
                @(negedge clk);
                if (bus.req_valid && bus.req_ready) begin
                    if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
                    else            exp_q.push_back(ref_mem[bus.req_addr]);
                    pend = 0;
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    chk("rnd_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0)
                        chk($sformatf("rnd_data%0d", cyc), 64'(bus.resp_rdata), 64'(exp_q.pop_front()));
                end
                next();
                if (!pend) bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                chk("drain_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0)
                    chk("drain_data", 64'(bus.resp_rdata), 64'(exp_q.pop_front()));
            end
            next();
        end
        chk("rnd_left", 64'(exp_q.size()), 64'(0));
        chk("no_dual_enable", 64'(both_seen), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
